tilt_decoder: RTL and testbench

//  Upstream stage of the ball-position block. Accepts raw signed X/Y accelerometer samples over a valid/ready handshake.

---
 rtl/tilt_pkg.sv | 24 ++
 rtl/tilt_axis.sv | 107 ++++++++++
 rtl/tilt_decoder.sv | 174 +++++++++++++++++
 tb/tb_tilt_decoder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tilt_pkg.sv
// Shared types and helpers for the tilt decoder.
// Contents: FSM state enum, neutral threshold code and 8-bit signed saturation.
package tilt_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    COMPUTE = 2'd1,
    PUBLISH = 2'd2
  } tilt_state_e;

  localparam logic [7:0] TILT_NEUTRAL = 8'd128;

  // Clamp a signed value to the 8-bit signed range [-128, 127].
  function automatic logic signed [7:0] sat8(input int v);
    if (v > 127) begin
      sat8 = 8'sd127;
    end else if (v < -128) begin
      sat8 = -8'sd128;
    end else begin
      sat8 = 8'(v);
    end
  endfunction

endpackage

// File: rtl/tilt_axis.sv
// One axis of the tilt decoder: sample accumulator, average, optional zero
// offset (TILT_CAL_EN), deadband and offset-binary threshold mapping.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   clear               drop the accumulated sum (publish cycle)
//   add                 accumulate sample (accepted transfer)
//   compute             register direction flags and threshold from the average
//   neutral             force outputs to level (timeout expiry)
//   cal_load            latch the last pre-offset average as offset (TILT_CAL_EN only)
//   sample              signed raw sample
//   increment/decrement direction flags; threshold 8-bit offset-binary tilt
module tilt_axis
  import tilt_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DEADBAND = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       add,
  input  logic                       compute,
  input  logic                       neutral,
`ifdef TILT_CAL_EN
  input  logic                       cal_load,
`endif
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       increment,
  output logic                       decrement,
  output logic [7:0]                 threshold
);

  localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int          DB    = int'(DEADBAND);

  logic signed [ACC_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] avg_raw_c;
  logic signed [SAMPLE_W-1:0] avg_c;
  logic                       outside_c;
  logic [7:0]                 thr_c;

  // Arithmetic shift gives a floor average that always fits SAMPLE_W bits.
  assign avg_raw_c = SAMPLE_W'(acc >>> AVG_LOG2);

`ifdef TILT_CAL_EN
  logic signed [SAMPLE_W-1:0] avg_pre;
  logic signed [SAMPLE_W-1:0] offset;
  logic signed [SAMPLE_W:0]   diff_c;

  // Offset subtraction, saturated back into the SAMPLE_W signed range.
  assign diff_c = {avg_raw_c[SAMPLE_W-1], avg_raw_c} - {offset[SAMPLE_W-1], offset};

  always_comb begin
    avg_c = diff_c[SAMPLE_W-1:0];
    if (diff_c[SAMPLE_W] != diff_c[SAMPLE_W-1]) begin
      avg_c = diff_c[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

  // avg_pre holds the average computed for the current publish cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_pre <= '0;
      offset  <= '0;
    end else begin
      if (compute) avg_pre <= avg_raw_c;
      if (cal_load) offset <= avg_pre;
    end
  end
`else
  assign avg_c = avg_raw_c;
`endif

  // Deadband test and threshold mapping.
  always_comb begin
    int a;
    a         = int'(avg_c);
    outside_c = (a > DB) || (a < -DB);
    thr_c     = 8'(int'(sat8(a >>> (SAMPLE_W - 8))) + 128);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      increment <= 1'b0;
      decrement <= 1'b0;
      threshold <= TILT_NEUTRAL;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (add) begin
        acc <= acc + ACC_W'(sample);
      end
      if (compute) begin
        increment <= outside_c && !avg_c[SAMPLE_W-1];
        decrement <= outside_c && avg_c[SAMPLE_W-1];
        threshold <= outside_c ? thr_c : TILT_NEUTRAL;
      end else if (neutral) begin
        increment <= 1'b0;
        decrement <= 1'b0;
        threshold <= TILT_NEUTRAL;
      end
    end
  end

endmodule

// File: rtl/tilt_decoder.sv
// Tilt decoder: averages signed X/Y accelerometer samples taken over a
// valid/ready handshake and publishes per-axis direction flags and an
// offset-binary tilt magnitude for the ball-position block.
// Optional feature macro: TILT_CAL_EN (cal_strobe captures a zero offset).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   sample_valid/sample_ready  sample handshake (transfer = valid & ready)
//   x_sample, y_sample         signed raw samples
//   cal_strobe                 zero-offset capture request (TILT_CAL_EN only)
//   x/y_increment, x/y_decrement, x/y_threshold  per-axis tilt outputs
//   update                     one-cycle pulse when outputs refresh
//   stale                      high while the sample timeout has expired
module tilt_decoder
  import tilt_pkg::*;
#(
  parameter int unsigned SAMPLE_W       = 12,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned DEADBAND       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned CNTR_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic signed [SAMPLE_W-1:0] x_sample,
  input  logic signed [SAMPLE_W-1:0] y_sample,
  input  logic                       cal_strobe,
  output logic                       x_increment,
  output logic                       x_decrement,
  output logic                       y_increment,
  output logic                       y_decrement,
  output logic [7:0]                 x_threshold,
  output logic [7:0]                 y_threshold,
  output logic                       update,
  output logic                       stale
);

  localparam int unsigned           CNT_W    = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNTR_WIDTH-1:0] TO_SAT   = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTR_WIDTH-1:0] TO_ARM   = CNTR_WIDTH'(TIMEOUT_CYCLES - 2);

  tilt_state_e           state;
  logic [CNT_W-1:0]      count;
  logic [CNTR_WIDTH-1:0] idle_cnt;
  logic                  transfer_c;
  logic                  expire_c;
  logic                  compute_c;
  logic                  publish_c;
  logic                  cal_load_c;

  assign transfer_c = sample_valid && sample_ready;
  assign compute_c  = (state == COMPUTE);
  assign publish_c  = (state == PUBLISH);
  // Expiry fires once as the idle counter steps onto its saturation value;
  // a concurrent refresh from COMPUTE takes priority.
  assign expire_c   = !transfer_c && (idle_cnt == TO_ARM) && !compute_c;

`ifdef TILT_CAL_EN
  logic cal_pend;

  assign cal_load_c = publish_c && (cal_strobe || cal_pend);

  // A strobe outside PUBLISH waits for the next PUBLISH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cal_pend <= 1'b0;
    end else if (publish_c) begin
      cal_pend <= 1'b0;
    end else if (cal_strobe) begin
      cal_pend <= 1'b1;
    end
  end
`else
  logic cal_unused;

  assign cal_load_c = 1'b0;
  assign cal_unused = cal_strobe | cal_load_c;
`endif

  // Control FSM, handshake, sample counter, timeout and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ACCUM;
      count        <= '0;
      idle_cnt     <= '0;
      sample_ready <= 1'b0;
      update       <= 1'b0;
      stale        <= 1'b0;
    end else begin
      update <= 1'b0;
      if (transfer_c) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_SAT) begin
        idle_cnt <= idle_cnt + CNTR_WIDTH'(1);
      end
      if (expire_c) begin
        stale  <= 1'b1;
        update <= 1'b1;
      end
      case (state)
        ACCUM: begin
          sample_ready <= 1'b1;
          if (transfer_c) begin
            if (count == LAST_IDX) begin
              count        <= '0;
              state        <= COMPUTE;
              sample_ready <= 1'b0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        // Outputs are registered here so they are valid during PUBLISH.
        COMPUTE: begin
          state        <= PUBLISH;
          sample_ready <= 1'b0;
          update       <= 1'b1;
          stale        <= 1'b0;
        end
        PUBLISH: begin
          state        <= ACCUM;
          sample_ready <= 1'b1;
        end
        default: begin
          state        <= ACCUM;
          sample_ready <= 1'b0;
        end
      endcase
    end
  end

  tilt_axis #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2),
    .DEADBAND (DEADBAND)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .clear     (publish_c),
    .add       (transfer_c),
    .compute   (compute_c),
    .neutral   (expire_c),
`ifdef TILT_CAL_EN
    .cal_load  (cal_load_c),
`endif
    .sample    (x_sample),
    .increment (x_increment),
    .decrement (x_decrement),
    .threshold (x_threshold)
  );

  tilt_axis #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2),
    .DEADBAND (DEADBAND)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .clear     (publish_c),
    .add       (transfer_c),
    .compute   (compute_c),
    .neutral   (expire_c),
`ifdef TILT_CAL_EN
    .cal_load  (cal_load_c),
`endif
    .sample    (y_sample),
    .increment (y_increment),
    .decrement (y_decrement),
    .threshold (y_threshold)
  );

endmodule

// File: tb/tb_tilt_decoder.sv
// Self-checking bench for tilt_decoder (SAMPLE_W=12, AVG_LOG2=2, DEADBAND=16,
// TIMEOUT_CYCLES=50). Expected outputs come from an arithmetic model of the
// averaging, deadband and threshold rules.
module tb_tilt_decoder;

  localparam int DB = 16;
  localparam int TO = 50;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sample_valid = 1'b0;
  logic               cal_strobe = 1'b0;
  logic signed [11:0] x_sample = '0;
  logic signed [11:0] y_sample = '0;
  logic               sample_ready;
  logic               x_increment, x_decrement, y_increment, y_decrement;
  logic [7:0]         x_threshold, y_threshold;
  logic               update, stale;

  int n_cmp = 0;
  int n_err = 0;
  int edge_no = 0;
  int last_xfer_edge = 0;
  int xoff = 0;
  int yoff = 0;

  tilt_decoder #(
    .SAMPLE_W       (12),
    .AVG_LOG2       (2),
    .DEADBAND       (16),
    .TIMEOUT_CYCLES (TO),
    .CNTR_WIDTH     (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .x_sample     (x_sample),
    .y_sample     (y_sample),
    .cal_strobe   (cal_strobe),
    .x_increment  (x_increment),
    .x_decrement  (x_decrement),
    .y_increment  (y_increment),
    .y_decrement  (y_decrement),
    .x_threshold  (x_threshold),
    .y_threshold  (y_threshold),
    .update       (update),
    .stale        (stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  // ---------------- reference model ----------------
  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int axis_avg(input int s[4], input int off);
    int v;
    v = fdiv(s[0] + s[1] + s[2] + s[3], 4) - off;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v;
  endfunction

  // {inc, dec, threshold}
  function automatic logic [9:0] axis_out(input int avg);
    int t;
    if (avg <= DB && avg >= -DB) return {2'b00, 8'd128};
    t = fdiv(avg, 16);
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return {avg > 0, avg < 0, 8'(t + 128)};
  endfunction

  // {update@COMPUTE, ready@COMPUTE, update@PUBLISH, ready@PUBLISH, x, y, stale}
  function automatic logic [24:0] group_exp(input int xs[4], input int ys[4]);
    return {4'b0010, axis_out(axis_avg(xs, xoff)), axis_out(axis_avg(ys, yoff)), 1'b0};
  endfunction

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int x, input int y, output int waits);
    sample_valid = 1'b1;
    x_sample = 12'(x);
    y_sample = 12'(y);
    waits = 0;
    while (!sample_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_ready_timeout: ready=%b after %0d cycles, required 1", sample_ready, waits);
    end
    @(negedge clk);
    last_xfer_edge = edge_no;
  endtask

  // Four samples, then observe the COMPUTE and PUBLISH cycles.
  task automatic run_group(input int xs[4], input int ys[4], input bit hold, input int hx,
                           input int hy, output logic [24:0] obs, output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], ys[i], w);
      if (i == 0) first_wait = w;
    end
    if (hold) begin
      x_sample = 12'(hx);
      y_sample = 12'(hy);
    end else begin
      sample_valid = 1'b0;
    end
    obs[24] = update;
    obs[23] = sample_ready;
    @(negedge clk);
    obs[22] = update;
    obs[21] = sample_ready;
    obs[20:0] = {x_increment, x_decrement, x_threshold, y_increment, y_decrement, y_threshold, stale};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({x_increment, x_decrement, x_threshold, y_increment, y_decrement, y_threshold,
         update, stale, sample_ready} !== {2'b00, 8'd128, 2'b00, 8'd128, 3'b000}) begin
      n_err++;
      $display("FAIL reset_values: got %b %b %0d %b %b %0d upd=%b stale=%b rdy=%b, required neutral/0",
               x_increment, x_decrement, x_threshold, y_increment, y_decrement, y_threshold,
               update, stale, sample_ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    int xs[4], ys[4], w;
    logic [24:0] obs, exp;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin xs = '{1024, 1024, 1024, 1024}; ys = '{0, 0, 0, 0}; end
        1: begin xs = '{0, 0, 0, 0}; ys = '{-2048, -2048, -2048, -2048}; end
        2: begin xs = '{0, 0, 0, 0}; ys = '{2047, 2047, 2047, 2047}; end
        3: begin xs = '{10, 20, -5, 15}; ys = '{0, 0, 0, 0}; end
        4: begin xs = '{17, 17, 17, 17}; ys = '{-16, -16, -16, -16}; end
        5: begin xs = '{16, 16, 16, 16}; ys = '{-17, -17, -17, -17}; end
        6: begin xs = '{-2048, 2047, -2048, 2047}; ys = '{-3, -4, -3, -4}; end
        default: begin xs = '{-1000, -1001, -999, -1002}; ys = '{500, 600, 700, 800}; end
      endcase
      exp = group_exp(xs, ys);
      run_group(xs, ys, 1'b0, 0, 0, obs, w);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL directed_%0d: got %h, required %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    int xs[4], ys[4], w;
    logic [24:0] obs, exp;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (c % 2 == 0) begin
          xs[i] = int'($urandom_range(4095)) - 2048;
          ys[i] = int'($urandom_range(4095)) - 2048;
        end else begin
          xs[i] = int'($urandom_range(80)) - 40;
          ys[i] = int'($urandom_range(80)) - 40;
        end
      end
      exp = group_exp(xs, ys);
      run_group(xs, ys, 1'b0, 0, 0, obs, w);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL random_%0d: x=%0d,%0d,%0d,%0d y=%0d,%0d,%0d,%0d got %h, required %h",
                 c, xs[0], xs[1], xs[2], xs[3], ys[0], ys[1], ys[2], ys[3], obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int xa[4], ya[4], xb[4], yb[4], w, e0;
    logic [24:0] obs, exp;
    xa = '{300, 300, 300, 300};     ya = '{-300, -300, -300, -300};
    xb = '{-800, 100, 100, 100};    yb = '{900, 0, 0, 0};
    exp = group_exp(xa, ya);
    run_group(xa, ya, 1'b1, xb[0], yb[0], obs, w);
    e0 = last_xfer_edge;
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL b2b_first: got %h, required %h", obs, exp);
    end
    exp = group_exp(xb, yb);
    run_group(xb, yb, 1'b0, 0, 0, obs, w);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL b2b_second: got %h, required %h", obs, exp);
    end
    n_cmp++;
    if (w != 1 || last_xfer_edge - e0 != 6) begin
      n_err++;
      $display("FAIL b2b_timing: wait=%0d period=%0d, required wait=1 period=6", w, last_xfer_edge - e0);
    end
  endtask

  task automatic test_timeout();
    int xs[4], ys[4], w, e0, n;
    logic [24:0] obs, exp;
    xs = '{1024, 1024, 1024, 1024}; ys = '{0, 0, 0, 0};
    exp = group_exp(xs, ys);
    run_group(xs, ys, 1'b0, 0, 0, obs, w);
    e0 = last_xfer_edge;
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL timeout_pre: got %h, required %h", obs, exp);
    end
    n = 0;
    while (!stale && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (stale !== 1'b1 || edge_no - e0 != TO - 1 ||
        {update, x_increment, x_decrement, x_threshold} !== {3'b100, 8'd128}) begin
      n_err++;
      $display("FAIL timeout_expire: stale=%b after %0d edges upd=%b xi=%b xd=%b xt=%0d, required 1 after %0d, 1 0 0 128",
               stale, edge_no - e0, update, x_increment, x_decrement, x_threshold, TO - 1);
    end
    @(negedge clk);
    n_cmp++;
    if ({update, stale} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_pulse: update=%b stale=%b, required 0 1", update, stale);
    end
    xs = '{-40, -40, -40, -40};
    exp = group_exp(xs, ys);
    run_group(xs, ys, 1'b0, 0, 0, obs, w);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL timeout_recover: got %h, required %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    int xs[4], ys[4], w;
    logic [24:0] obs, exp;
    send(2000, -2000, w);
    send(2000, -2000, w);
    sample_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({x_increment, x_decrement, x_threshold, y_increment, y_decrement, y_threshold,
         update, stale, sample_ready} !== {2'b00, 8'd128, 2'b00, 8'd128, 3'b000}) begin
      n_err++;
      $display("FAIL reset_mid: got %b %b %0d %b %b %0d upd=%b stale=%b rdy=%b, required neutral/0",
               x_increment, x_decrement, x_threshold, y_increment, y_decrement, y_threshold,
               update, stale, sample_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    xs = '{-512, -512, -512, -512}; ys = '{64, 64, 64, 64};
    exp = group_exp(xs, ys);
    run_group(xs, ys, 1'b0, 0, 0, obs, w);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_mid_avg: got %h, required %h", obs, exp);
    end
  endtask

`ifdef TILT_CAL_EN
  task automatic test_cal();
    int xs[4], ys[4], w;
    logic [24:0] obs, exp;
    xs = '{320, 320, 320, 320}; ys = '{0, 0, 0, 0};
    exp = group_exp(xs, ys);
    run_group(xs, ys, 1'b0, 0, 0, obs, w);
    cal_strobe = 1'b1;
    @(negedge clk);
    cal_strobe = 1'b0;
    xoff = 320;
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL cal_capture: got %h, required %h", obs, exp);
    end
    exp = group_exp(xs, ys);
    run_group(xs, ys, 1'b0, 0, 0, obs, w);
    n_cmp++;
    if (obs !== exp || x_threshold !== 8'd128) begin
      n_err++;
      $display("FAIL cal_zero: got %h thr=%0d, required %h thr=128", obs, x_threshold, exp);
    end
    xs = '{-2048, -2048, -2048, -2048};
    exp = group_exp(xs, ys);
    run_group(xs, ys, 1'b0, 0, 0, obs, w);
    n_cmp++;
    if (obs !== exp || x_threshold !== 8'd0) begin
      n_err++;
      $display("FAIL cal_saturate: got %h thr=%0d, required %h thr=0", obs, x_threshold, exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef TILT_CAL_EN
    test_cal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
